// File: rtl/pat_search_engine.sv
// Pattern search engine: loads a 5-bit pattern from memory, scans N_BYTES message
// bytes and counts pattern matches three ways (in-byte windows, bytes with any
// in-byte match, and windows across the whole bit string). It then writes the
// three counts back to memory and raises done.
module pat_search_engine #(
  parameter int unsigned PAT_ADDR = 32,
  parameter int unsigned RES_BASE = 33,
  parameter int unsigned N_BYTES  = 32
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req_i,
  output logic       done_o,
  output logic [7:0] mem_addr_o,
  input  logic [7:0] mem_rd_data_i,
  output logic       mem_wr_en_o,
  output logic [7:0] mem_wr_data_o
);

  localparam logic [7:0] PatAddr = 8'(PAT_ADDR);
  localparam logic [7:0] ResCtb  = 8'(RES_BASE);
  localparam logic [7:0] ResCto  = 8'(RES_BASE + 1);
  localparam logic [7:0] ResCts  = 8'(RES_BASE + 2);
  localparam logic [7:0] LastIdx = 8'(N_BYTES - 1);

  typedef enum logic [2:0] {
    StIdle, StLdPat, StScan, StDrain, StWrCtb, StWrCto, StWrCts, StDone
  } state_e;

  state_e      state_q, state_d;
  logic        req_q;
  logic [7:0]  idx_q, idx_d;
  logic [4:0]  pat_q, pat_d;
  logic [3:0]  carry_q, carry_d;
  logic        first_q, first_d;
  logic [7:0]  ctb_q, ctb_d;
  logic [7:0]  cto_q, cto_d;
  logic [7:0]  cts_q, cts_d;

  logic        proc;
  logic [11:0] win;
  logic [2:0]  m4;
  logic [3:0]  m8;

  // Register req once; the FSM acts on the sampled level one cycle later.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) req_q <= 1'b0;
    else         req_q <= req_i;
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (req_q) state_d = StLdPat;
      StLdPat: state_d = StScan;
      StScan:  if (idx_q == LastIdx) state_d = StDrain;
      StDrain: state_d = StWrCtb;
      StWrCtb: state_d = StWrCto;
      StWrCto: state_d = StWrCts;
      StWrCts: state_d = StDone;
      StDone:  if (req_q) state_d = StLdPat;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: memory bus and done, decoded from the current state only.
  always_comb begin
    done_o        = 1'b0;
    mem_addr_o    = 8'd0;
    mem_wr_en_o   = 1'b0;
    mem_wr_data_o = 8'd0;
    case (state_q)
      StLdPat: mem_addr_o = PatAddr;
      StScan:  mem_addr_o = idx_q;
      StWrCtb: begin
        mem_wr_en_o   = 1'b1;
        mem_addr_o    = ResCtb;
        mem_wr_data_o = ctb_q;
      end
      StWrCto: begin
        mem_wr_en_o   = 1'b1;
        mem_addr_o    = ResCto;
        mem_wr_data_o = cto_q;
      end
      StWrCts: begin
        mem_wr_en_o   = 1'b1;
        mem_addr_o    = ResCts;
        mem_wr_data_o = cts_q;
      end
      StDone:  done_o = 1'b1;
      default: ;
    endcase
  end

  // Window matching on the byte currently on the read bus. Windows 0..3 of
  // {carry, byte} lie inside the byte; windows 4..7 straddle the byte boundary.
  always_comb begin
    proc = ((state_q == StScan) && (idx_q != 8'd0)) || (state_q == StDrain);
    win  = {carry_q, mem_rd_data_i};
    m4   = 3'd0;
    m8   = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (win[i +: 5] == pat_q) begin
        m8 = m8 + 4'd1;
        if (i < 4) m4 = m4 + 3'd1;
      end
    end
  end

  // Datapath next-state: scan address, pattern capture and counters.
  always_comb begin
    idx_d   = idx_q;
    pat_d   = pat_q;
    carry_d = carry_q;
    first_d = first_q;
    ctb_d   = ctb_q;
    cto_d   = cto_q;
    cts_d   = cts_q;
    case (state_q)
      StLdPat: begin
        idx_d   = 8'd0;
        carry_d = 4'd0;
        first_d = 1'b1;
        ctb_d   = 8'd0;
        cto_d   = 8'd0;
        cts_d   = 8'd0;
      end
      StScan: begin
        idx_d = idx_q + 8'd1;
        // Read data in the first scan cycle is the pattern word.
        if (idx_q == 8'd0) pat_d = mem_rd_data_i[4:0];
      end
      default: ;
    endcase
    if (proc) begin
      ctb_d   = ctb_q + {5'd0, m4};
      if (m4 != 3'd0) cto_d = cto_q + 8'd1;
      // Byte 0 has no predecessor, so only its in-byte windows count.
      cts_d   = cts_q + (first_q ? {5'd0, m4} : {4'd0, m8});
      carry_d = mem_rd_data_i[3:0];
      first_d = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q   <= 8'd0;
      pat_q   <= 5'd0;
      carry_q <= 4'd0;
      first_q <= 1'b0;
      ctb_q   <= 8'd0;
      cto_q   <= 8'd0;
      cts_q   <= 8'd0;
    end else begin
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      carry_q <= carry_d;
      first_q <= first_d;
      ctb_q   <= ctb_d;
      cto_q   <= cto_d;
      cts_q   <= cts_d;
    end
  end

endmodule

// File: doc/pat_search_engine.md
PAT_SEARCH_ENGINE -- requirements
Module: pat_search_engine

Interface
REQ-001 SHALL have parameter PAT_ADDR, default 32, byte address of the pattern word.
REQ-002 SHALL have parameter RES_BASE, default 33, first of three result addresses (RES_BASE, +1, +2).
REQ-003 SHALL have parameter N_BYTES, default 32, number of message bytes at addresses 0..N_BYTES-1.
REQ-004 clk  input  1  single clock, rising-edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req  input  1  start request, level-sampled on clk.
REQ-007 done  output  1  job complete; results are in memory.
REQ-008 mem_addr  output  8  data-memory address.
REQ-009 mem_rd_data  input  8  read data; valid one cycle after mem_addr is presented.
REQ-010 mem_wr_en  output  1  write strobe, one cycle per write.
REQ-011 mem_wr_data  output  8  write data, paired with mem_addr.

Function
REQ-012 SHALL use FSM states IDLE, LDPAT, SCAN, DRAIN, WR_CTB, WR_CTO, WR_CTS, DONE.
REQ-013 IDLE: req=1 at an edge -> LDPAT; otherwise stay.
REQ-014 LDPAT (1 cycle): drive mem_addr=PAT_ADDR; clear the ctb, cto and cts counters and the carry register -> SCAN.
REQ-015 SCAN: drive mem_addr=0..N_BYTES-1, one per cycle; in the first SCAN cycle capture pat=mem_rd_data[4:0]; leave after address N_BYTES-1 -> DRAIN.
REQ-016 Byte k SHALL be processed in the cycle its data is valid, i.e. the cycle after address k; DRAIN (1 cycle) processes the last byte.
REQ-017 ctb SHALL add the number of matches of pat among b[4:0], b[5:1], b[6:2], b[7:3] of each byte b (0..4 per byte).
REQ-018 cto SHALL increment by 1 for each byte with at least one ctb match.
REQ-019 cts SHALL treat the message as one bit string, byte 0 most significant and bit 7 first, and count all 5-bit windows (N_BYTES*8-4 windows).
REQ-020 For byte 0, cts SHALL add the same 4 in-byte window matches.
REQ-021 For byte k>=1, cts SHALL form w={byte(k-1)[3:0], byte k} (12 bits) and add the matches among w[11:7] down to w[4:0] (8 windows).
REQ-022 The carry register SHALL hold byte(k-1)[3:0], updated in each cycle a byte is processed.
REQ-023 All counters SHALL be 8 bits; for default parameters the maxima are ctb 128, cto 32, cts 252, so no saturation logic is needed.
REQ-024 WR_CTB, WR_CTO, WR_CTS SHALL each take 1 cycle, driving mem_wr_en=1, mem_addr=RES_BASE+0/+1/+2 and mem_wr_data=ctb/cto/cts respectively.
REQ-025 mem_wr_en SHALL be 0 in every other state.
REQ-026 DONE: done=1; req=1 at an edge -> LDPAT (done drops the next cycle); otherwise stay.
REQ-027 done SHALL be 0 in every state except DONE.
REQ-028 Latency SHALL be: req sampled at edge E0 -> done=1 after edge E0+N_BYTES+6 (38 for defaults).
REQ-029 req changes while the FSM is not in IDLE or DONE SHALL be ignored.
REQ-030 When idle (IDLE, DONE), mem_addr SHALL be 0 and mem_wr_data 0.

Reset
REQ-031 reset=0 SHALL immediately force: state IDLE, done=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, all counters, pat and carry 0.
REQ-032 reset asserted mid-job SHALL abort the job with no further memory writes; a partial result is never written.
REQ-033 After reset release, the block SHALL wait in IDLE for req.

Verification
REQ-034 All message bytes 0x00, mem[32]=0x00, pulse req -> mem[33]=128, mem[34]=32, mem[35]=252; done rises exactly 38 cycles after req is sampled.
REQ-035 All bytes 0x55, pat 5'b10101 -> mem[33]=64, mem[34]=32, mem[35]=126.
REQ-036 All bytes 0x00, pat 5'b11111 -> mem[33]=0, mem[34]=0, mem[35]=0; exactly three write strobes, at addresses 33, 34, 35.
REQ-037 1000 random memories and patterns, checked against a behavioural model of REQ-017..021 -> all three counts match every run.
REQ-038 reset pulsed low during SCAN (cycle 15) -> no writes, done=0; a later req gives correct counts.
REQ-039 req held high through DONE -> the job restarts; done drops for one full job; the second results are identical to the first.
